// File: rtl/qec_pkg.sv
// ============================================================================
// Module : qec_pkg
// Steane [[7,1,3]] parity-check columns, FSM state type, syndrome function.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package qec_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MEAS  = 2'd1,
        APPLY = 2'd2
    } qec_state_e;

    // Entry [i] is the parity-check column for qubit i
    localparam logic [6:0][2:0] STEANE_COL = {
        3'b100, 3'b010, 3'b001, 3'b110, 3'b101, 3'b011, 3'b111
    };

    function automatic logic [2:0] steane_syndrome(input logic [6:0] err);
        logic [2:0] s;
        s = '0;
        for (int i = 0; i < 7; i++) begin
            if (err[i]) begin
                s = s ^ STEANE_COL[i];
            end
        end
        return s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/qec_steane_syndrome_calc.sv
// ============================================================================
// Module : qec_steane_syndrome_calc
// Combinational Steane syndrome of one 7-qubit Pauli error component.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module qec_steane_syndrome_calc
    import qec_pkg::*;
(
    input  logic [6:0] frame,
    output logic [2:0] syndrome
);

    always_comb begin
        syndrome = steane_syndrome(frame);
    end

endmodule

`default_nettype wire

// File: rtl/qec_steane_syndrome_unit.sv
// ============================================================================
// Module : qec_steane_syndrome_unit
// Pauli error frame with latency-modelled syndrome extraction and correction.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module qec_steane_syndrome_unit
    import qec_pkg::*;
#(
    parameter int MEAS_LATENCY  = 4,
    parameter int APPLY_LATENCY = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       measure_start,
    output logic       measure_done,
    output logic [2:0] syndrome_x,
    output logic [2:0] syndrome_z,
    input  logic       apply_start,
    output logic       apply_done,
    input  logic [6:0] correction_x,
    input  logic [6:0] correction_z,
    input  logic       inject_valid,
    input  logic [6:0] inject_x,
    input  logic [6:0] inject_z,
    input  logic       frame_clear,
    output logic [6:0] frame_x,
    output logic [6:0] frame_z,
    output logic       logical_x,
    output logic       logical_z,
    output logic       busy
);

    localparam int MAX_LAT = (MEAS_LATENCY > APPLY_LATENCY) ? MEAS_LATENCY : APPLY_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    // The accept cycle is the first latency cycle, so the counter starts at LATENCY-2
    localparam logic [CNT_W-1:0] MEAS_LOAD  = CNT_W'((MEAS_LATENCY  > 1) ? MEAS_LATENCY  - 2 : 0);
    localparam logic [CNT_W-1:0] APPLY_LOAD = CNT_W'((APPLY_LATENCY > 1) ? APPLY_LATENCY - 2 : 0);

    qec_state_e       state_q,      state_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic             armed_m_q,    armed_m_d;
    logic             armed_a_q,    armed_a_d;
    logic [6:0]       corr_x_q,     corr_x_d;
    logic [6:0]       corr_z_q,     corr_z_d;
    logic [6:0]       frame_x_q,    frame_x_d;
    logic [6:0]       frame_z_q,    frame_z_d;
    logic [2:0]       syn_x_q,      syn_x_d;
    logic [2:0]       syn_z_q,      syn_z_d;
    logic             meas_done_q,  meas_done_d;
    logic             apply_done_q, apply_done_d;

    logic       idle_ready;
    logic       accept_m;
    logic       accept_a;
    logic       meas_final;
    logic       apply_final;
    logic [6:0] corr_eff_x;
    logic [6:0] corr_eff_z;
    logic [2:0] syn_x_calc;
    logic [2:0] syn_z_calc;

    qec_steane_syndrome_calc u_syn_z (
        .frame    (frame_x_q),
        .syndrome (syn_z_calc)
    );

    qec_steane_syndrome_calc u_syn_x (
        .frame    (frame_z_q),
        .syndrome (syn_x_calc)
    );

    // The done cycle still counts as busy, so no new request is taken in it
    assign idle_ready  = (state_q == IDLE) && !meas_done_q && !apply_done_q;
    assign accept_m    = idle_ready && measure_start && armed_m_q;
    assign accept_a    = idle_ready && !accept_m && apply_start && armed_a_q;
    assign meas_final  = ((state_q == MEAS)  && (cnt_q == '0)) || (accept_m && (MEAS_LATENCY  == 1));
    assign apply_final = ((state_q == APPLY) && (cnt_q == '0)) || (accept_a && (APPLY_LATENCY == 1));
    assign corr_eff_x  = (state_q == APPLY) ? corr_x_q : correction_x;
    assign corr_eff_z  = (state_q == APPLY) ? corr_z_q : correction_z;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            armed_m_q    <= 1'b1;
            armed_a_q    <= 1'b1;
            corr_x_q     <= '0;
            corr_z_q     <= '0;
            frame_x_q    <= '0;
            frame_z_q    <= '0;
            syn_x_q      <= '0;
            syn_z_q      <= '0;
            meas_done_q  <= 1'b0;
            apply_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            armed_m_q    <= armed_m_d;
            armed_a_q    <= armed_a_d;
            corr_x_q     <= corr_x_d;
            corr_z_q     <= corr_z_d;
            frame_x_q    <= frame_x_d;
            frame_z_q    <= frame_z_d;
            syn_x_q      <= syn_x_d;
            syn_z_q      <= syn_z_d;
            meas_done_q  <= meas_done_d;
            apply_done_q <= apply_done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept_m && !meas_final) begin
                    state_d = MEAS;
                    cnt_d   = MEAS_LOAD;
                end else if (accept_a && !apply_final) begin
                    state_d = APPLY;
                    cnt_d   = APPLY_LOAD;
                end
            end
            MEAS, APPLY: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        armed_m_d = armed_m_q;
        armed_a_d = armed_a_q;
        if (meas_final) begin
            armed_m_d = 1'b0;
        end
        if (!measure_start) begin
            armed_m_d = 1'b1;
        end
        if (apply_final) begin
            armed_a_d = 1'b0;
        end
        if (!apply_start) begin
            armed_a_d = 1'b1;
        end

        corr_x_d = accept_a ? correction_x : corr_x_q;
        corr_z_d = accept_a ? correction_z : corr_z_q;

        frame_x_d = frame_x_q ^ (inject_valid ? inject_x : 7'd0)
                              ^ (apply_final  ? corr_eff_x : 7'd0);
        frame_z_d = frame_z_q ^ (inject_valid ? inject_z : 7'd0)
                              ^ (apply_final  ? corr_eff_z : 7'd0);
        if (frame_clear) begin
            frame_x_d = '0;
            frame_z_d = '0;
        end

        // Sampling the registered frame keeps a same-cycle inject out of the syndrome
        syn_x_d      = meas_final ? syn_x_calc : syn_x_q;
        syn_z_d      = meas_final ? syn_z_calc : syn_z_q;
        meas_done_d  = meas_final;
        apply_done_d = apply_final;
    end

    always_comb begin
        measure_done = meas_done_q;
        apply_done   = apply_done_q;
        syndrome_x   = syn_x_q;
        syndrome_z   = syn_z_q;
        frame_x      = frame_x_q;
        frame_z      = frame_z_q;
        logical_x    = ^frame_x_q;
        logical_z    = ^frame_z_q;
        busy         = (state_q != IDLE) || meas_done_q || apply_done_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_qec_steane_syndrome_unit.sv
// ============================================================================
// Module : tb_qec_steane_syndrome_unit
// Directed vectors for qec_steane_syndrome_unit with hand-computed results.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_qec_steane_syndrome_unit;

    localparam int MEAS_LATENCY  = 4;
    localparam int APPLY_LATENCY = 2;

    logic       clk;
    logic       rst_n;
    logic       measure_start;
    logic       measure_done;
    logic [2:0] syndrome_x;
    logic [2:0] syndrome_z;
    logic       apply_start;
    logic       apply_done;
    logic [6:0] correction_x;
    logic [6:0] correction_z;
    logic       inject_valid;
    logic [6:0] inject_x;
    logic [6:0] inject_z;
    logic       frame_clear;
    logic [6:0] frame_x;
    logic [6:0] frame_z;
    logic       logical_x;
    logic       logical_z;
    logic       busy;

    int n_cmp;
    int n_err;

    qec_steane_syndrome_unit #(
        .MEAS_LATENCY  (MEAS_LATENCY),
        .APPLY_LATENCY (APPLY_LATENCY)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .measure_start (measure_start),
        .measure_done  (measure_done),
        .syndrome_x    (syndrome_x),
        .syndrome_z    (syndrome_z),
        .apply_start   (apply_start),
        .apply_done    (apply_done),
        .correction_x  (correction_x),
        .correction_z  (correction_z),
        .inject_valid  (inject_valid),
        .inject_x      (inject_x),
        .inject_z      (inject_z),
        .frame_clear   (frame_clear),
        .frame_x       (frame_x),
        .frame_z       (frame_z),
        .logical_x     (logical_x),
        .logical_z     (logical_z),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_inject(input logic [6:0] ix, input logic [6:0] iz,
                             input logic [6:0] exp_fx, input logic [6:0] exp_fz, input string tag);
        @(negedge clk);
        inject_valid = 1'b1;
        inject_x     = ix;
        inject_z     = iz;
        @(negedge clk);
        inject_valid = 1'b0;
        check({tag, "_fx"}, 32'(frame_x), 32'(exp_fx));
        check({tag, "_fz"}, 32'(frame_z), 32'(exp_fz));
    endtask

    task automatic do_clear();
        @(negedge clk);
        frame_clear = 1'b1;
        @(negedge clk);
        frame_clear = 1'b0;
        check("clear_frame", 32'({frame_x, frame_z}), 32'd0);
    endtask

    // Request is held 4 cycles past done to prove it is not re-accepted
    task automatic do_measure(input string tag, input logic [2:0] exp_sx, input logic [2:0] exp_sz,
                              input logic inj_final, input logic [6:0] ix);
        int lat;
        int extra;
        @(negedge clk);
        measure_start = 1'b1;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            inject_valid = 1'b0;
            if (measure_done) begin
                lat = k;
                break;
            end
            check({tag, "_busy"}, 32'(busy), 32'd1);
            if (inj_final && k == MEAS_LATENCY - 1) begin
                inject_valid = 1'b1;
                inject_x     = ix;
                inject_z     = 7'd0;
            end
        end
        check({tag, "_lat"}, lat, MEAS_LATENCY);
        check({tag, "_done_busy"}, 32'(busy), 32'd1);
        check({tag, "_sx"}, 32'(syndrome_x), 32'(exp_sx));
        check({tag, "_sz"}, 32'(syndrome_z), 32'(exp_sz));
        extra = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (measure_done) extra++;
        end
        check({tag, "_held_pulses"}, extra, 0);
        measure_start = 1'b0;
        @(negedge clk);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    // Correction inputs are scrambled after acceptance to prove they were captured
    task automatic do_apply(input string tag, input logic [6:0] cx, input logic [6:0] cz,
                            input logic inj, input logic [6:0] ix, input logic [6:0] iz,
                            input logic [6:0] exp_fx, input logic [6:0] exp_fz);
        int lat;
        int extra;
        @(negedge clk);
        apply_start  = 1'b1;
        correction_x = cx;
        correction_z = cz;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            inject_valid = 1'b0;
            correction_x = ~cx;
            correction_z = ~cz;
            if (apply_done) begin
                lat = k;
                break;
            end
            if (inj && k == APPLY_LATENCY - 1) begin
                inject_valid = 1'b1;
                inject_x     = ix;
                inject_z     = iz;
            end
        end
        check({tag, "_lat"}, lat, APPLY_LATENCY);
        check({tag, "_fx"}, 32'(frame_x), 32'(exp_fx));
        check({tag, "_fz"}, 32'(frame_z), 32'(exp_fz));
        extra = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (apply_done) extra++;
        end
        check({tag, "_held_pulses"}, extra, 0);
        apply_start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int pulses;
        n_cmp = 0;
        n_err = 0;
        rst_n         = 1'b0;
        measure_start = 1'b0;
        apply_start   = 1'b0;
        correction_x  = '0;
        correction_z  = '0;
        inject_valid  = 1'b0;
        inject_x      = '0;
        inject_z      = '0;
        frame_clear   = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_outputs", 32'({measure_done, apply_done, syndrome_x, syndrome_z,
                                  frame_x, frame_z, logical_x, logical_z, busy}), 32'd0);

        // Single X error on qubit 0
        do_inject(7'b0000001, 7'b0000000, 7'b0000001, 7'b0000000, "inj_x0");
        check("inj_x0_logx", 32'(logical_x), 32'd1);
        do_measure("meas_x0", 3'b000, 3'b111, 1'b0, 7'd0);

        // Correct it and re-measure
        do_apply("apply_x0", 7'b0000001, 7'b0000000, 1'b0, 7'd0, 7'd0, 7'b0000000, 7'b0000000);
        check("apply_x0_logx", 32'(logical_x), 32'd0);
        do_measure("remeas_x0", 3'b000, 3'b000, 1'b0, 7'd0);

        // Single Z error on qubit 5
        do_clear();
        do_inject(7'b0000000, 7'b0100000, 7'b0000000, 7'b0100000, "inj_z5");
        check("inj_z5_logz", 32'(logical_z), 32'd1);
        do_measure("meas_z5", 3'b010, 3'b000, 1'b0, 7'd0);

        // Y error on qubit 3
        do_clear();
        do_inject(7'b0001000, 7'b0001000, 7'b0001000, 7'b0001000, "inj_y3");
        do_measure("meas_y3", 3'b110, 3'b110, 1'b0, 7'd0);

        // Weight-2 error miscorrected into a logical flip
        do_clear();
        do_inject(7'b0000011, 7'b0000000, 7'b0000011, 7'b0000000, "inj_w2");
        do_measure("meas_w2", 3'b000, 3'b100, 1'b0, 7'd0);
        do_apply("apply_w2", 7'b1000000, 7'b0000000, 1'b0, 7'd0, 7'd0, 7'b1000011, 7'b0000000);
        do_measure("remeas_w2", 3'b000, 3'b000, 1'b0, 7'd0);
        check("w2_logx", 32'(logical_x), 32'd1);

        // Inject coincident with the apply final cycle
        do_apply("apply_inj", 7'b0010000, 7'b0000001, 1'b1, 7'b0000100, 7'b0000010,
                 7'b1010111, 7'b0000011);

        // Inject in the final measure cycle must not reach the syndrome
        do_measure("meas_inj", 3'b100, 3'b100, 1'b1, 7'b0000001);
        check("meas_inj_fx", 32'(frame_x), 32'b1010110);

        // Reset during the second measure cycle
        @(negedge clk);
        measure_start = 1'b1;
        repeat (2) @(negedge clk);
        rst_n         = 1'b0;
        measure_start = 1'b0;
        #1;
        check("rst_mid_outputs", 32'({measure_done, apply_done, syndrome_x, syndrome_z,
                                      frame_x, frame_z, busy}), 32'd0);
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (measure_done) pulses++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (measure_done) pulses++;
        end
        check("rst_mid_no_done", pulses, 0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        do_measure("meas_post_rst", 3'b000, 3'b000, 1'b0, 7'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
